// File: rtl/input_feeder_pkg.sv
// -----------------------------------------------------------------------------
// input_feeder_pkg
// Shared definitions for the input skew feeder:
//   - feeder_state_e : tile sequencing FSM states (IDLE, FEED, DRAIN, DONE)
//   - LFSR_TAPS_<n>  : maximal-length Fibonacci tap masks, bit i = stage i+1
//   - lfsr_taps()    : selects the tap mask for a given register width
// -----------------------------------------------------------------------------
package input_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } feeder_state_e;

  localparam logic [31:0] LFSR_TAPS_3  = 32'h0000_0006;
  localparam logic [31:0] LFSR_TAPS_4  = 32'h0000_000C;
  localparam logic [31:0] LFSR_TAPS_5  = 32'h0000_0014;
  localparam logic [31:0] LFSR_TAPS_6  = 32'h0000_0030;
  localparam logic [31:0] LFSR_TAPS_7  = 32'h0000_0060;
  localparam logic [31:0] LFSR_TAPS_8  = 32'h0000_00B8;
  localparam logic [31:0] LFSR_TAPS_9  = 32'h0000_0110;
  localparam logic [31:0] LFSR_TAPS_10 = 32'h0000_0240;
  localparam logic [31:0] LFSR_TAPS_11 = 32'h0000_0500;
  localparam logic [31:0] LFSR_TAPS_12 = 32'h0000_0E08;
  localparam logic [31:0] LFSR_TAPS_13 = 32'h0000_1C80;
  localparam logic [31:0] LFSR_TAPS_14 = 32'h0000_3802;
  localparam logic [31:0] LFSR_TAPS_15 = 32'h0000_6000;
  localparam logic [31:0] LFSR_TAPS_16 = 32'h0000_B400;

  // Tap mask for a width; unsupported widths return 0 (LFSR would stick).
  function automatic logic [31:0] lfsr_taps(input int unsigned width);
    logic [31:0] taps;
    case (width)
      3:       taps = LFSR_TAPS_3;
      4:       taps = LFSR_TAPS_4;
      5:       taps = LFSR_TAPS_5;
      6:       taps = LFSR_TAPS_6;
      7:       taps = LFSR_TAPS_7;
      8:       taps = LFSR_TAPS_8;
      9:       taps = LFSR_TAPS_9;
      10:      taps = LFSR_TAPS_10;
      11:      taps = LFSR_TAPS_11;
      12:      taps = LFSR_TAPS_12;
      13:      taps = LFSR_TAPS_13;
      14:      taps = LFSR_TAPS_14;
      15:      taps = LFSR_TAPS_15;
      16:      taps = LFSR_TAPS_16;
      default: taps = 32'h0000_0000;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// -----------------------------------------------------------------------------
// skew_delay_line
// Fixed-depth shift register used to skew one PE row. Shifts every cycle,
// never stalls; asynchronous active-high reset clears every stage.
//   clk  in  1      rising-edge clock
//   rst  in  1      asynchronous active-high reset
//   d    in  WIDTH  value entering the line
//   q    out WIDTH  value after DEPTH cycles (DEPTH must be >= 1)
// -----------------------------------------------------------------------------
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  // Next value of every stage: the previous stage, or d for the first one.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 0) begin
        stage_d[i] = d;
      end else begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  // Stage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/input_skew_feeder.sv
// -----------------------------------------------------------------------------
// input_skew_feeder
// Accepts a tile of k_len signed input vectors, converts each element to
// sign-magnitude and feeds row r of a PE array r+1 cycles after the beat is
// accepted, so the array sees a diagonal wavefront.
//
// Optional feature macro: INPUT_FEEDER_LFSR_EN
//   defined   : per-row maximal-length LFSR (seed r+1) supplies random numbers
//   undefined : random numbers come from port ext_rand_in, captured per beat
//
// Ports
//   clk, reset               clock / asynchronous active-high reset
//   start, k_len             tile start pulse and tile length (IDLE only)
//   in_valid, in_ready       beat handshake, in_data = ROW_NUM x IN_W signed
//   ext_rand_in              per-row random input (macro undefined only)
//   input_abs_stream         ROW_NUM x (IN_W-1) skewed magnitudes
//   input_sign_stream        ROW_NUM skewed signs
//   b_i_rand_stream          ROW_NUM x RAND_W skewed random numbers
//   row_valid, row_last      per-row beat-present / final-beat flags
//   M_end                    latched k_len replicated per row
//   busy, done               tile in progress / one-cycle completion pulse
// -----------------------------------------------------------------------------
module input_skew_feeder
  import input_feeder_pkg::*;
#(
  parameter int ROW_NUM = 8,
  parameter int IN_W    = 8,
  parameter int RAND_W  = 8,
  parameter int MEND_W  = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [MEND_W-1:0]           k_len,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [ROW_NUM*IN_W-1:0]     in_data,
`ifndef INPUT_FEEDER_LFSR_EN
  input  logic [ROW_NUM*RAND_W-1:0]   ext_rand_in,
`endif
  output logic [ROW_NUM*(IN_W-1)-1:0] input_abs_stream,
  output logic [ROW_NUM-1:0]          input_sign_stream,
  output logic [ROW_NUM*RAND_W-1:0]   b_i_rand_stream,
  output logic [ROW_NUM-1:0]          row_valid,
  output logic [ROW_NUM-1:0]          row_last,
  output logic [ROW_NUM*MEND_W-1:0]   M_end,
  output logic                        busy,
  output logic                        done
);

  localparam int ABS_W    = IN_W - 1;
  // Per-row payload: {valid, last, sign, abs, rand}
  localparam int BUNDLE_W = 3 + ABS_W + RAND_W;
  localparam int DRN_W    = $clog2(ROW_NUM + 1);

  // Two's complement -> {sign, magnitude}; the most negative value saturates.
  function automatic logic [IN_W-1:0] to_sign_mag(input logic [IN_W-1:0] x);
    logic [IN_W-1:0] neg;
    logic [IN_W-1:0] res;
    neg = -x;
    if (x == {1'b1, {ABS_W{1'b0}}}) begin
      res = {1'b1, {ABS_W{1'b1}}};
    end else if (x[IN_W-1]) begin
      res = {1'b1, neg[ABS_W-1:0]};
    end else begin
      res = {1'b0, x[ABS_W-1:0]};
    end
    return res;
  endfunction

  feeder_state_e     state_q, state_d;
  logic [MEND_W-1:0] count_q, count_d;
  logic [MEND_W-1:0] m_end_q, m_end_d;
  logic [DRN_W-1:0]  drain_q, drain_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              xfer;
  logic              last_beat;
  logic [RAND_W-1:0] rand_cur [ROW_NUM];

  // in_ready_q is high exactly while the FSM sits in FEED.
  assign xfer      = in_valid & in_ready_q;
  assign last_beat = xfer & (count_q == (m_end_q - MEND_W'(1)));

  // FSM next-state and registered-output decode.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    m_end_d = m_end_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_end_d = k_len;
          count_d = '0;
          if (k_len != '0) begin
            state_d = FEED;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      FEED: begin
        if (xfer) begin
          count_d = count_q + MEND_W'(1);
          if (last_beat) begin
            state_d = DRAIN;
            drain_d = '0;
          end else begin
            state_d = FEED;
          end
        end else begin
          state_d = FEED;
        end
      end
      DRAIN: begin
        // Gives the last beat time to walk down to the bottom row.
        if (drain_q == DRN_W'(ROW_NUM - 1)) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q + DRN_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d = (state_d == FEED);
    busy_d     = (state_d == FEED) || (state_d == DRAIN);
    done_d     = (state_d == DONE);
  end

  // FSM state, counters and registered control outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      m_end_q    <= '0;
      drain_q    <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      m_end_q    <= m_end_d;
      drain_q    <= drain_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

`ifdef INPUT_FEEDER_LFSR_EN
  localparam logic [31:0] LFSR_TAPS = lfsr_taps(RAND_W);

  logic [RAND_W-1:0] lfsr_q [ROW_NUM];
  logic [RAND_W-1:0] lfsr_d [ROW_NUM];

  // Each beat carries the current LFSR value; the LFSR then steps once.
  always_comb begin
    for (int r = 0; r < ROW_NUM; r++) begin
      rand_cur[r] = lfsr_q[r];
      if (xfer) begin
        lfsr_d[r] = {lfsr_q[r][RAND_W-2:0], ^(lfsr_q[r] & LFSR_TAPS[RAND_W-1:0])};
      end else begin
        lfsr_d[r] = lfsr_q[r];
      end
    end
  end

  // Per-row LFSR registers, seeded with row index + 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < ROW_NUM; r++) begin
        lfsr_q[r] <= RAND_W'(r + 1);
      end
    end else begin
      for (int r = 0; r < ROW_NUM; r++) begin
        lfsr_q[r] <= lfsr_d[r];
      end
    end
  end
`else
  // Random numbers come straight from the external port on each beat.
  always_comb begin
    for (int r = 0; r < ROW_NUM; r++) begin
      rand_cur[r] = ext_rand_in[r*RAND_W +: RAND_W];
    end
  end
`endif

  logic [BUNDLE_W-1:0] stage_q [ROW_NUM];
  logic [BUNDLE_W-1:0] stage_d [ROW_NUM];
  logic [BUNDLE_W-1:0] row_out [ROW_NUM];

  // Input stage: converted beat on a transfer, all-zero bubble otherwise.
  always_comb begin
    for (int r = 0; r < ROW_NUM; r++) begin
      if (xfer) begin
        stage_d[r] = {1'b1, last_beat, to_sign_mag(in_data[r*IN_W +: IN_W]), rand_cur[r]};
      end else begin
        stage_d[r] = '0;
      end
    end
  end

  // Input stage registers (the first cycle of latency for every row).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < ROW_NUM; r++) begin
        stage_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < ROW_NUM; r++) begin
        stage_q[r] <= stage_d[r];
      end
    end
  end

  // Row r gets r additional cycles of delay; row 0 is the input stage itself.
  for (genvar r = 0; r < ROW_NUM; r++) begin : g_row
    if (r == 0) begin : g_direct
      assign row_out[r] = stage_q[r];
    end else begin : g_skew
      skew_delay_line #(
        .DEPTH(r),
        .WIDTH(BUNDLE_W)
      ) u_skew (
        .clk (clk),
        .rst (reset),
        .d   (stage_q[r]),
        .q   (row_out[r])
      );
    end
  end

  // Unpack the per-row payloads onto the flat output buses.
  always_comb begin
    for (int r = 0; r < ROW_NUM; r++) begin
      row_valid[r]                          = row_out[r][BUNDLE_W-1];
      row_last[r]                           = row_out[r][BUNDLE_W-2];
      input_sign_stream[r]                  = row_out[r][BUNDLE_W-3];
      input_abs_stream[r*ABS_W +: ABS_W]    = row_out[r][RAND_W +: ABS_W];
      b_i_rand_stream[r*RAND_W +: RAND_W]   = row_out[r][RAND_W-1:0];
      M_end[r*MEND_W +: MEND_W]             = m_end_q;
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_input_skew_feeder.sv
// Directed bench for input_skew_feeder (ROW_NUM=4, IN_W=8, RAND_W=8, MEND_W=8).
// Timing convention: inputs change and outputs are sampled 1 ns after a
// rising edge. "+n" means the n-th sample counted from the accepting edge,
// so row r of a beat is expected at the sample taken r edges after it.
module tb_input_skew_feeder;

  localparam int ROW_NUM = 4;
  localparam int IN_W    = 8;
  localparam int RAND_W  = 8;
  localparam int MEND_W  = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  k_len;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [31:0] ext_rand_in;
  logic [27:0] abs_s;
  logic [3:0]  sign_s;
  logic [31:0] rand_s;
  logic [3:0]  row_valid;
  logic [3:0]  row_last;
  logic [31:0] m_end;
  logic        busy;
  logic        done;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  input_skew_feeder #(
    .ROW_NUM(ROW_NUM), .IN_W(IN_W), .RAND_W(RAND_W), .MEND_W(MEND_W)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .k_len            (k_len),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data          (in_data),
`ifndef INPUT_FEEDER_LFSR_EN
    .ext_rand_in      (ext_rand_in),
`endif
    .input_abs_stream (abs_s),
    .input_sign_stream(sign_s),
    .b_i_rand_stream  (rand_s),
    .row_valid        (row_valid),
    .row_last         (row_last),
    .M_end            (m_end),
    .busy             (busy),
    .done             (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    start       = 1'b0;
    k_len       = 8'd0;
    in_valid    = 1'b0;
    in_data     = 32'h0;
    ext_rand_in = 32'h0;
  endtask

  // Ticks for a fixed budget, reporting first done sample and number of done samples.
  task automatic wait_done(input int budget, output int at, output int n);
    at = -1;
    n  = 0;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (done === 1'b1) begin
        n++;
        if (at < 0) at = i;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; k_len = 8'd9;
    in_valid = 1'b1; in_data = 32'hA5A5_A5A5; ext_rand_in = 32'hFFFF_FFFF;
    tick(); tick();
    tests++; if (in_ready !== 1'b0) begin failed++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin failed++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (row_valid !== 4'b0000 || row_last !== 4'b0000) begin failed++; $display("FAIL reset_flags got %b/%b want 0000/0000", row_valid, row_last); end
    tests++; if (abs_s !== 28'h0 || sign_s !== 4'b0000) begin failed++; $display("FAIL reset_data got %h/%b want 0/0", abs_s, sign_s); end
    tests++; if (rand_s !== 32'h0 || m_end !== 32'h0) begin failed++; $display("FAIL reset_rand_mend got %h/%h want 0/0", rand_s, m_end); end
    drive_idle();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_beat();
    logic [3:0]  exp_valid [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [27:0] exp_abs   [4] = '{28'd5, 28'd0, 28'd127 << 14, 28'd127 << 21};
    logic [3:0]  exp_sign  [4] = '{4'b0001, 4'b0000, 4'b0000, 4'b1000};
`ifdef INPUT_FEEDER_LFSR_EN
    logic [31:0] exp_rand  [4] = '{32'h0000_0001, 32'h0000_0200, 32'h0003_0000, 32'h0400_0000};
`else
    logic [31:0] exp_rand  [4] = '{32'h0000_0011, 32'h0000_2200, 32'h0033_0000, 32'h4400_0000};
`endif
    int at, n;
    start = 1'b1; k_len = 8'd1;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 32'h807F_00FB; ext_rand_in = 32'h4433_2211;
    tick();
    in_valid = 1'b0; in_data = 32'h0; ext_rand_in = 32'h0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      tests++; if (row_valid !== exp_valid[k] || row_last !== exp_valid[k]) begin failed++; $display("FAIL single_flags +%0d got %b/%b want %b/%b", k + 1, row_valid, row_last, exp_valid[k], exp_valid[k]); end
      tests++; if (abs_s !== exp_abs[k] || sign_s !== exp_sign[k]) begin failed++; $display("FAIL single_data +%0d got %h/%b want %h/%b", k + 1, abs_s, sign_s, exp_abs[k], exp_sign[k]); end
      tests++; if (rand_s !== exp_rand[k]) begin failed++; $display("FAIL single_rand +%0d got %h want %h", k + 1, rand_s, exp_rand[k]); end
    end
    wait_done(6, at, n);
    tests++; if (at !== 1 || n !== 1) begin failed++; $display("FAIL single_done got at=%0d n=%0d want at=1 n=1", at, n); end
  endtask

  task automatic test_continuous();
    logic [31:0] beats [3] = '{32'h0101_0101, 32'hFEFE_FEFE, 32'h0303_0303};
    int at, n;
    start = 1'b1; k_len = 8'd3;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    for (int b = 0; b < 3; b++) begin
      in_data = beats[b];
      tick();
      tests++; if (in_ready !== (b < 2 ? 1'b1 : 1'b0)) begin failed++; $display("FAIL cont_in_ready beat%0d got %b want %b", b, in_ready, (b < 2 ? 1'b1 : 1'b0)); end
    end
    // Row0 holds beat2, row1 beat1, row2 beat0, row3 nothing yet.
    tests++; if (row_valid !== 4'b0111 || row_last !== 4'b0001) begin failed++; $display("FAIL cont_wave_flags got %b/%b want 0111/0001", row_valid, row_last); end
    tests++; if (abs_s !== 28'd16643 || sign_s !== 4'b0010) begin failed++; $display("FAIL cont_wave_data got %0d/%b want 16643/0010", abs_s, sign_s); end
    in_data = 32'h7F7F_7F7F;  // in_valid stays high but must be ignored now
    wait_done(8, at, n);
    tests++; if (at !== 4 || n !== 1) begin failed++; $display("FAIL cont_done got at=%0d n=%0d want at=4 n=1", at, n); end
    tests++; if (m_end !== 32'h0303_0303) begin failed++; $display("FAIL cont_m_end got %h want 03030303", m_end); end
    tests++; if (row_valid !== 4'b0000 || busy !== 1'b0) begin failed++; $display("FAIL cont_ignored got valid=%b busy=%b want 0000/0", row_valid, busy); end
    drive_idle();
  endtask

  task automatic test_bubbles();
    int          sched [7] = '{0, 1, 0, 0, 2, 3, 4};   // beat sent at edge c (0 = none)
    logic [31:0] bdata [5] = '{32'h0, 32'h0A0A_0A0A, 32'h1414_1414, 32'h1E1E_1E1E, 32'hD8D8_D8D8};
    logic [6:0]  babs  [5] = '{7'd0, 7'd10, 7'd20, 7'd30, 7'd40};
    logic [3:0]  ev, el, es;
    logic [27:0] ea;
    int at, n, beat, c;
    start = 1'b1; k_len = 8'd4;
    tick();
    start = 1'b0;
    for (int t = 1; t <= 9; t++) begin
      if (t <= 6 && sched[t] != 0) begin
        in_valid = 1'b1; in_data = bdata[sched[t]];
      end else begin
        in_valid = 1'b0; in_data = 32'h0;
      end
      tick();
      ev = 4'b0; el = 4'b0; es = 4'b0; ea = 28'h0;
      for (int r = 0; r < 4; r++) begin
        c = t - r;
        beat = (c >= 1 && c <= 6) ? sched[c] : 0;
        if (beat != 0) begin
          ev[r] = 1'b1;
          el[r] = (beat == 4);
          es[r] = (beat == 4);
          ea[r*7 +: 7] = babs[beat];
        end
      end
      tests++; if (row_valid !== ev || row_last !== el) begin failed++; $display("FAIL bubble_flags t%0d got %b/%b want %b/%b", t, row_valid, row_last, ev, el); end
      tests++; if (abs_s !== ea || sign_s !== es) begin failed++; $display("FAIL bubble_data t%0d got %h/%b want %h/%b", t, abs_s, sign_s, ea, es); end
    end
    in_valid = 1'b0;
    wait_done(6, at, n);
    tests++; if (at !== 1 || n !== 1) begin failed++; $display("FAIL bubble_done got at=%0d n=%0d want at=1 n=1", at, n); end
  endtask

  task automatic test_zero_and_busy_start();
    int at;
    start = 1'b1; k_len = 8'd0;
    tick();
    start = 1'b0;
    tests++; if (done !== 1'b1 || busy !== 1'b0 || row_valid !== 4'b0000) begin failed++; $display("FAIL zero_done got done=%b busy=%b valid=%b want 1/0/0000", done, busy, row_valid); end
    tick();
    tests++; if (done !== 1'b0 || row_valid !== 4'b0000) begin failed++; $display("FAIL zero_after got done=%b valid=%b want 0/0000", done, row_valid); end
    // Start held high through a whole k_len=2 tile must not disturb it.
    start = 1'b1; k_len = 8'd2;
    tick();
    k_len = 8'd5;
    in_valid = 1'b1; in_data = 32'h0102_0304;
    tick();
    tests++; if (busy !== 1'b1) begin failed++; $display("FAIL busy_start_busy got %b want 1", busy); end
    tick();
    tests++; if (in_ready !== 1'b0) begin failed++; $display("FAIL busy_start_ready got %b want 0", in_ready); end
    at = -1;
    for (int i = 1; i <= 8 && at < 0; i++) begin
      tick();
      if (done === 1'b1) begin
        at = i;
        start = 1'b0;
        in_valid = 1'b0;
      end
    end
    drive_idle();
    tests++; if (at !== 4) begin failed++; $display("FAIL busy_start_done got at=%0d want 4", at); end
    tests++; if (m_end !== 32'h0202_0202) begin failed++; $display("FAIL busy_start_m_end got %h want 02020202", m_end); end
    tick();
    tests++; if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin failed++; $display("FAIL busy_start_idle got %b%b%b want 000", busy, in_ready, done); end
  endtask

  task automatic test_reset_mid_feed();
    int at, n, stray;
    start = 1'b1; k_len = 8'd5;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 32'h0707_0707; ext_rand_in = 32'h5555_5555;
    tick(); tick();
    tests++; if (row_valid !== 4'b0011 || busy !== 1'b1) begin failed++; $display("FAIL mid_pre got valid=%b busy=%b want 0011/1", row_valid, busy); end
    #1;
    reset = 1'b1; in_valid = 1'b0;
    #1;
    tests++; if (row_valid !== 4'b0000 || abs_s !== 28'h0 || sign_s !== 4'b0000) begin failed++; $display("FAIL mid_clear_data got %b/%h/%b want 0000/0/0000", row_valid, abs_s, sign_s); end
    tests++; if (busy !== 1'b0 || in_ready !== 1'b0 || m_end !== 32'h0 || rand_s !== 32'h0) begin failed++; $display("FAIL mid_clear_ctrl got busy=%b rdy=%b mend=%h rand=%h want 0/0/0/0", busy, in_ready, m_end, rand_s); end
    tick();
    reset = 1'b0;
    drive_idle();
    stray = 0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done === 1'b1) n++;
      if (row_valid !== 4'b0000) stray++;
    end
    tests++; if (n !== 0 || stray !== 0) begin failed++; $display("FAIL mid_no_done got done=%0d valid_cycles=%0d want 0/0", n, stray); end
    start = 1'b1; k_len = 8'd1;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 32'hF9F9_F9F9; ext_rand_in = 32'h0A0B_0C0D;
    tick();
    drive_idle();
    tests++; if (row_valid !== 4'b0001 || abs_s[6:0] !== 7'd7 || sign_s !== 4'b0001) begin failed++; $display("FAIL mid_rerun_row0 got %b/%0d/%b want 0001/7/0001", row_valid, abs_s[6:0], sign_s); end
    tick(); tick();
    tests++; if (row_valid !== 4'b0100 || abs_s[20:14] !== 7'd7) begin failed++; $display("FAIL mid_rerun_row2 got %b/%0d want 0100/7", row_valid, abs_s[20:14]); end
`ifdef INPUT_FEEDER_LFSR_EN
    tests++; if (rand_s[23:16] !== 8'd3) begin failed++; $display("FAIL mid_rerun_rand got %h want 03", rand_s[23:16]); end
`else
    tests++; if (rand_s[23:16] !== 8'h0B) begin failed++; $display("FAIL mid_rerun_rand got %h want 0b", rand_s[23:16]); end
`endif
    wait_done(6, at, n);
    tests++; if (at !== 2 || n !== 1) begin failed++; $display("FAIL mid_rerun_done got at=%0d n=%0d want at=2 n=1", at, n); end
  endtask

  initial begin
    drive_idle();
    reset = 1'b1;
    test_reset();
    test_single_beat();
    test_continuous();
    test_bubbles();
    test_zero_and_busy_start();
    test_reset_mid_feed();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
